host_queue_arbiter_mc: RTL and testbench
========================================

Name: host_queue_arbiter_mc

Overview:
- Parametrised multi-channel descriptor queue for the host transmit path.
- Accepts {tsntag, bufid} descriptors from NUM_CH request channels (hcp, network, further host ports) through a wr/ack handshake.
- Arbitrates between channels in fixed-priority or round-robin mode and buffers compacted descriptors in an internal synchronous FIFO.
- Delivers descriptors to the downstream scheduler under ready flow control, and reports FIFO occupancy and a high-water mark.

Parameters:
- NUM_CH, 2, number of request channels (1..8).
- TAG_W, 48, tsntag width per channel.
- BUFID_W, 9, bufid width.
- TAGK_W, 14, number of tsntag bits kept in the descriptor.
- TAG_LSB, 0, lowest tsntag bit kept.
- DEPTH, 16, FIFO depth in entries (power of 2).
- ARB_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin.
- Derived, not overridable: DESC_W = TAGK_W+BUFID_W; CNT_W = log2(DEPTH)+1.

Ports:
- Interface decision: one clock; reset is asynchronous and active-high.
- i_clk  in  1  system clock.
- i_rst  in  1  asynchronous reset, active-high.
- iv_tsntag  in  NUM_CH*TAG_W  channel c occupies bits [c*TAG_W +: TAG_W].
- iv_bufid  in  NUM_CH*BUFID_W  channel c occupies bits [c*BUFID_W +: BUFID_W].
- iv_descriptor_wr  in  NUM_CH  per-channel request, level, held until acked.
- ov_descriptor_ack  out  NUM_CH  per-channel one-cycle acknowledge.
- ov_descriptor  out  DESC_W  {tsntag[TAG_LSB +: TAGK_W], bufid}.
- o_descriptor_wr  out  1  one-cycle strobe; ov_descriptor is valid in that cycle.
- i_descriptor_ready  in  1  downstream can accept a descriptor.
- ov_fifo_usedw  out  CNT_W  current FIFO occupancy.
- o_fifo_full  out  1  occupancy == DEPTH.
- ov_usedw_max  out  CNT_W  maximum occupancy since reset or clear.
- i_watermark_clr  in  1  one-cycle pulse; loads ov_usedw_max with current occupancy.

Behaviour:
- Reset (asynchronous, any cycle): all outputs 0. FIFO emptied. RR pointer = 0. Any pending grant is discarded; its ack is not issued and its data is not written.
- Input handshake:
  - Cycle t: arbiter evaluates eligible = iv_descriptor_wr & ~ov_descriptor_ack. The currently acked channel is masked because its wr is still high.
  - Grant requires space: (usedw + write_pending) < DEPTH. Reads in cycle t are not credited (conservative).
  - Grant g at t: the descriptor of g is captured at t. At t+1, ov_descriptor_ack[g] = 1 and the captured entry is written to the FIFO.
  - Requester deasserts wr or presents a new descriptor by t+2.
  - At most one grant per cycle, so sustained throughput is one descriptor per cycle across all channels.
- Arbitration:
  - ARB_MODE 0: lowest eligible index wins.
  - ARB_MODE 1: search starts at ptr; after grant g, ptr = (g+1) mod NUM_CH. ptr is unchanged when there is no grant.
  - NUM_CH = 1: arbitration is bypassed, and the ack/mask rules still apply.
- Full: no grants while the space check fails. Requests stay pending; nothing is dropped and no ack is issued.
- Output:
  - Cycle t: if i_descriptor_ready and FIFO non-empty, the head is popped; at t+1, o_descriptor_wr = 1 with ov_descriptor = head.
  - Back-to-back strobes occur while ready stays high and data remains.
  - ov_descriptor holds its last value when wr = 0.
- Latency from request to output: request at t, FIFO write at t+1, visible non-empty at t+2, o_descriptor_wr at t+3 if ready was high at t+2.
- Occupancy:
  - usedw updates on the cycle after the write/pop: +1 write, -1 pop, unchanged for a simultaneous write and pop.
  - Read-when-empty and write-when-full cannot occur by construction.
  - Bench asserts on usedw > DEPTH.
- Watermark: ov_usedw_max = max(ov_usedw_max, usedw) every cycle. i_watermark_clr overrides this and loads usedw.

Test Plan:
- Single request: ch0 wr with tsntag = 48'h0000_0000_3ABC, bufid = 9'h05 at t -> ack[0] at t+1; o_descriptor_wr at t+3 with ov_descriptor = {14'h3ABC, 9'h05}; usedw 0 -> 1 -> 0.
- Round-robin with NUM_CH = 2: both channels request continuously with new descriptors each ack -> grants alternate 0,1,0,1; ptr wraps. With ARB_MODE = 0 -> only ch0 is granted while it requests.
- Full, DEPTH = 16, ready low: ch0 requests continuously -> exactly 16 acks; o_fifo_full = 1; usedw = 16; no 17th ack. Raise ready -> 16 strobes in FIFO order; the held request is acked after space appears.
- Simultaneous write/pop at usedw = 5 -> usedw stays 5, FIFO order is preserved, and ov_usedw_max never exceeds the true peak.
- Reset mid-operation: assert i_rst one cycle after a grant -> no ack and no write. After release, all outputs are 0, ptr = 0, usedw = 0, and the next request is acked normally.
- Watermark: fill to 9, drain to 2 -> ov_usedw_max = 9; pulse i_watermark_clr -> 2.

Source files
------------

// File: rtl/host_queue_arbiter_mc_if.sv
// Host transmit descriptor bus: NUM_CH request channels in, one scheduler channel out,
// plus occupancy/watermark status and a round-robin pointer debug view.
`timescale 1ns/1ps
interface host_queue_arbiter_mc_if #(
    parameter int NUM_CH  = 2,
    parameter int TAG_W   = 48,
    parameter int BUFID_W = 9,
    parameter int TAGK_W  = 14,
    parameter int DEPTH   = 16
);
    localparam int DESC_W = TAGK_W + BUFID_W;
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int PTR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    // Handshakes: a request channel holds iv_descriptor_wr and its tsntag/bufid stable until
    // it sees its one-cycle ov_descriptor_ack, then drops wr or presents the next descriptor.
    // o_descriptor_wr is a one-cycle strobe for a pop made while i_descriptor_ready was high.
    logic [NUM_CH*TAG_W-1:0]   iv_tsntag;
    logic [NUM_CH*BUFID_W-1:0] iv_bufid;
    logic [NUM_CH-1:0]         iv_descriptor_wr;
    logic [NUM_CH-1:0]         ov_descriptor_ack;
    logic [DESC_W-1:0]         ov_descriptor;
    logic                      o_descriptor_wr;
    logic                      i_descriptor_ready;
    logic [CNT_W-1:0]          ov_fifo_usedw;
    logic                      o_fifo_full;
    logic [CNT_W-1:0]          ov_usedw_max;
    logic                      i_watermark_clr;
    logic [PTR_W-1:0]          rr_ptr;

    modport master (
        output iv_tsntag, iv_bufid, iv_descriptor_wr, i_descriptor_ready, i_watermark_clr,
        input  ov_descriptor_ack, ov_descriptor, o_descriptor_wr, ov_fifo_usedw,
               o_fifo_full, ov_usedw_max, rr_ptr
    );

    modport slave (
        input  iv_tsntag, iv_bufid, iv_descriptor_wr, i_descriptor_ready, i_watermark_clr,
        output ov_descriptor_ack, ov_descriptor, o_descriptor_wr, ov_fifo_usedw,
               o_fifo_full, ov_usedw_max, rr_ptr
    );
endinterface

// File: rtl/host_queue_arbiter_mc.sv
// Multi-channel host transmit descriptor queue: arbitrates NUM_CH requesters into a
// compacted-descriptor FIFO and delivers entries to the scheduler under ready flow control.
`timescale 1ns/1ps
module host_queue_arbiter_mc #(
    parameter int NUM_CH   = 2,
    parameter int TAG_W    = 48,
    parameter int BUFID_W  = 9,
    parameter int TAGK_W   = 14,
    parameter int TAG_LSB  = 0,
    parameter int DEPTH    = 16,
    parameter int ARB_MODE = 1
) (
    input logic i_clk,
    input logic i_rst,
    host_queue_arbiter_mc_if.slave bus
);
    localparam int DESC_W = TAGK_W + BUFID_W;
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PTR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0] eligible;
    logic [NUM_CH-1:0] grant_oh;
    logic [NUM_CH-1:0] ack;
    logic              grant_valid;
    logic [PTR_W-1:0]  grant_idx;
    logic [PTR_W-1:0]  rr_ptr;
    logic [DESC_W-1:0] ch_desc [NUM_CH];
    logic [DESC_W-1:0] grant_desc;
    logic [DESC_W-1:0] pend_desc;
    logic [DESC_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_addr;
    logic [AW-1:0]     rd_addr;
    logic [CNT_W-1:0]  usedw;
    logic [CNT_W-1:0]  usedw_max;
    logic [CNT_W:0]    committed;
    logic [DESC_W-1:0] desc_out;
    logic              desc_wr;
    logic              write_en;
    logic              space_ok;
    logic              pop;
    logic              unused_tag_bits;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch_desc
        assign ch_desc[c] = {bus.iv_tsntag[c*TAG_W + TAG_LSB +: TAGK_W],
                             bus.iv_bufid[c*BUFID_W +: BUFID_W]};
    end
    assign unused_tag_bits = ^bus.iv_tsntag;

    // The channel acked this cycle still holds wr high on a descriptor already taken.
    assign eligible = bus.iv_descriptor_wr & ~ack;
    // An acked grant is written this cycle, so it already owns a FIFO slot.
    assign write_en  = |ack;
    assign committed = {1'b0, usedw} + {{CNT_W{1'b0}}, write_en};
    assign space_ok  = committed < (CNT_W+1)'(DEPTH);
    assign pop       = bus.i_descriptor_ready && (usedw != '0);

    // Loops run high-to-low so the last match, the highest-priority one, wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        if (space_ok) begin
            if (ARB_MODE == 0 || NUM_CH == 1) begin
                for (int c = NUM_CH - 1; c >= 0; c--) begin
                    if (eligible[PTR_W'(c)]) begin
                        grant_valid = 1'b1;
                        grant_idx   = PTR_W'(c);
                    end
                end
            end else begin
                for (int k = NUM_CH - 1; k >= 0; k--) begin
                    if (eligible[PTR_W'((int'(rr_ptr) + k) % NUM_CH)]) begin
                        grant_valid = 1'b1;
                        grant_idx   = PTR_W'((int'(rr_ptr) + k) % NUM_CH);
                    end
                end
            end
        end
    end

    assign grant_oh   = grant_valid ? (NUM_CH'(1) << grant_idx) : '0;
    assign grant_desc = ch_desc[grant_idx];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ack       <= '0;
            pend_desc <= '0;
            rr_ptr    <= '0;
            wr_addr   <= '0;
            rd_addr   <= '0;
            usedw     <= '0;
            usedw_max <= '0;
            desc_out  <= '0;
            desc_wr   <= 1'b0;
        end else begin
            ack <= grant_oh;
            if (grant_valid) begin
                pend_desc <= grant_desc;
                if (ARB_MODE != 0 && NUM_CH > 1) begin
                    rr_ptr <= (int'(grant_idx) == NUM_CH - 1) ? '0 : grant_idx + 1'b1;
                end
            end
            if (write_en) begin
                wr_addr <= wr_addr + 1'b1;
            end
            desc_wr <= pop;
            if (pop) begin
                desc_out <= mem[rd_addr];
                rd_addr  <= rd_addr + 1'b1;
            end
            usedw <= usedw + CNT_W'(write_en) - CNT_W'(pop);
            if (bus.i_watermark_clr) begin
                usedw_max <= usedw;
            end else if (usedw > usedw_max) begin
                usedw_max <= usedw;
            end
        end
    end

    // Storage needs no reset: occupancy alone decides which entries are live.
    always_ff @(posedge i_clk) begin
        if (write_en) begin
            mem[wr_addr] <= pend_desc;
        end
    end

    assign bus.ov_descriptor_ack = ack;
    assign bus.ov_descriptor     = desc_out;
    assign bus.o_descriptor_wr   = desc_wr;
    assign bus.ov_fifo_usedw     = usedw;
    assign bus.o_fifo_full       = (usedw == CNT_W'(DEPTH));
    assign bus.ov_usedw_max      = usedw_max;
    assign bus.rr_ptr            = rr_ptr;
endmodule

// File: tb/tb_host_queue_arbiter_mc.sv
// Bench for host_queue_arbiter_mc: a round-robin instance checked against a queue model
// every cycle, plus a fixed-priority instance exercised by a short hand sequence.
`timescale 1ns/1ps
module tb_host_queue_arbiter_mc;
    localparam int NUM_CH  = 2;
    localparam int TAG_W   = 48;
    localparam int BUFID_W = 9;
    localparam int TAGK_W  = 14;
    localparam int TAG_LSB = 0;
    localparam int DEPTH   = 16;
    localparam int DESC_W  = TAGK_W + BUFID_W;
    localparam int CNT_W   = $clog2(DEPTH) + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- DUTs ----------------
    host_queue_arbiter_mc_if #(.NUM_CH(NUM_CH), .TAG_W(TAG_W), .BUFID_W(BUFID_W),
                               .TAGK_W(TAGK_W), .DEPTH(DEPTH)) bus_a ();
    host_queue_arbiter_mc_if #(.NUM_CH(NUM_CH), .TAG_W(TAG_W), .BUFID_W(BUFID_W),
                               .TAGK_W(TAGK_W), .DEPTH(DEPTH)) bus_b ();

    host_queue_arbiter_mc #(.NUM_CH(NUM_CH), .TAG_W(TAG_W), .BUFID_W(BUFID_W), .TAGK_W(TAGK_W),
                            .TAG_LSB(TAG_LSB), .DEPTH(DEPTH), .ARB_MODE(1))
        dut_a (.i_clk(clk), .i_rst(rst), .bus(bus_a.slave));
    host_queue_arbiter_mc #(.NUM_CH(NUM_CH), .TAG_W(TAG_W), .BUFID_W(BUFID_W), .TAGK_W(TAGK_W),
                            .TAG_LSB(TAG_LSB), .DEPTH(DEPTH), .ARB_MODE(0))
        dut_b (.i_clk(clk), .i_rst(rst), .bus(bus_b.slave));

    logic [TAG_W-1:0]   tag_a [NUM_CH];
    logic [BUFID_W-1:0] buf_a [NUM_CH];
    logic [TAG_W-1:0]   tag_b [NUM_CH];
    logic [BUFID_W-1:0] buf_b [NUM_CH];
    logic [NUM_CH-1:0]  wr_a = '0;
    logic [NUM_CH-1:0]  wr_b = '0;
    logic ready_a = 1'b0;
    logic clr_a   = 1'b0;
    logic ready_b = 1'b1;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_pack
        assign bus_a.iv_tsntag[c*TAG_W +: TAG_W]     = tag_a[c];
        assign bus_a.iv_bufid[c*BUFID_W +: BUFID_W]  = buf_a[c];
        assign bus_b.iv_tsntag[c*TAG_W +: TAG_W]     = tag_b[c];
        assign bus_b.iv_bufid[c*BUFID_W +: BUFID_W]  = buf_b[c];
    end
    assign bus_a.iv_descriptor_wr   = wr_a;
    assign bus_a.i_descriptor_ready = ready_a;
    assign bus_a.i_watermark_clr    = clr_a;
    assign bus_b.iv_descriptor_wr   = wr_b;
    assign bus_b.i_descriptor_ready = ready_b;
    assign bus_b.i_watermark_clr    = 1'b0;

    // ---------------- scoreboard / reference model ----------------
    int checks   = 0;
    int failures = 0;

    logic [DESC_W-1:0] exp_q [$];
    logic [DESC_W-1:0] sent_q [$];
    int                m_ack;
    logic [DESC_W-1:0] m_pend;
    int                m_ptr;
    logic              m_strobe;
    logic [DESC_W-1:0] m_desc;
    int                m_max;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DESC_W-1:0] cur_desc(input int c);
        return {tag_a[c][TAG_LSB +: TAGK_W], buf_a[c]};
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_ack = -1; m_pend = '0; m_ptr = 0;
        m_strobe = 1'b0; m_desc = '0; m_max = 0;
    endtask

    // One clock of the queue as described in words: mask the acked channel, grant only
    // if the committed occupancy leaves room, search round-robin from the pointer.
    task automatic model_step();
        int g;
        int used;
        logic [NUM_CH-1:0] elig;
        used = exp_q.size();
        elig = wr_a;
        if (m_ack >= 0) elig[m_ack] = 1'b0;
        g = -1;
        if (used + ((m_ack >= 0) ? 1 : 0) < DEPTH) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (g < 0 && elig[(m_ptr + k) % NUM_CH]) g = (m_ptr + k) % NUM_CH;
            end
        end
        m_max = clr_a ? used : ((used > m_max) ? used : m_max);
        m_strobe = ready_a && (used > 0);
        if (m_strobe) m_desc = exp_q.pop_front();
        if (m_ack >= 0) exp_q.push_back(m_pend);
        if (g >= 0) begin
            m_pend = cur_desc(g);
            m_ptr  = (g + 1) % NUM_CH;
        end
        m_ack = g;
    endtask

    task automatic check_a();
        logic [NUM_CH-1:0] e_ack;
        e_ack = (m_ack >= 0) ? (NUM_CH'(1) << m_ack) : '0;
        chk("ack",         64'(bus_a.ov_descriptor_ack), 64'(e_ack));
        chk("strobe",      64'(bus_a.o_descriptor_wr),   64'(m_strobe));
        chk("descriptor",  64'(bus_a.ov_descriptor),     64'(m_desc));
        chk("usedw",       64'(bus_a.ov_fifo_usedw),     64'(exp_q.size()));
        chk("full",        64'(bus_a.o_fifo_full),       64'(exp_q.size() == DEPTH));
        chk("usedw_max",   64'(bus_a.ov_usedw_max),      64'(m_max));
        chk("rr_ptr",      64'(bus_a.rr_ptr),            64'(m_ptr));
        chk("usedw_bound", 64'(bus_a.ov_fifo_usedw > CNT_W'(DEPTH)), 64'(0));
    endtask

    // ---------------- driver tasks ----------------
    task automatic new_desc(input int c);
        tag_a[c] = {16'($urandom), 32'($urandom)};
        buf_a[c] = 9'($urandom);
    endtask

    task automatic new_desc_b(input int c);
        tag_b[c] = {16'($urandom), 32'($urandom)};
        buf_b[c] = 9'($urandom);
    endtask

    // Inputs are set at the falling edge; the model advances, the DUT clocks, and
    // outputs are compared at the next falling edge.
    task automatic step();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_a();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wr_a = '0; ready_a = 1'b0; clr_a = 1'b0; wr_b = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_a();
    endtask

    typedef struct {
        logic [NUM_CH-1:0] wr;
        logic              ready;
        logic              clr;
        logic [NUM_CH-1:0] ack;
        logic              strobe;
        logic [CNT_W-1:0]  usedw;
        logic [CNT_W-1:0]  umax;
        logic [DESC_W-1:0] desc;
    } vec_t;
    vec_t vecs [5];

    int n_ack;
    int n_rx;
    int bias;

    initial begin
        // Single request, one row per cycle; expectations are visible after that cycle's edge.
        vecs[0] = '{2'b01, 1'b0, 1'b0, 2'b01, 1'b0, 5'd0, 5'd0, 23'h000000};
        vecs[1] = '{2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 5'd1, 5'd0, 23'h000000};
        vecs[2] = '{2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 5'd0, 5'd1, 23'h757805};
        vecs[3] = '{2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 5'd1, 23'h757805};
        vecs[4] = '{2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 5'd0, 5'd0, 23'h757805};
        for (int c = 0; c < NUM_CH; c++) begin
            new_desc(c);
            new_desc_b(c);
        end

        do_reset();
        chk("b_reset_ack",   64'(bus_b.ov_descriptor_ack), 64'(0));
        chk("b_reset_usedw", 64'(bus_b.ov_fifo_usedw),     64'(0));
        chk("b_reset_desc",  64'(bus_b.ov_descriptor),     64'(0));

        // ---- table: single request ----
        tag_a[0] = 48'h0000_0000_3ABC;
        buf_a[0] = 9'h05;
        for (int i = 0; i < 5; i++) begin
            wr_a = vecs[i].wr; ready_a = vecs[i].ready; clr_a = vecs[i].clr;
            step();
            chk("vec_ack",    64'(bus_a.ov_descriptor_ack), 64'(vecs[i].ack));
            chk("vec_strobe", 64'(bus_a.o_descriptor_wr),   64'(vecs[i].strobe));
            chk("vec_usedw",  64'(bus_a.ov_fifo_usedw),     64'(vecs[i].usedw));
            chk("vec_max",    64'(bus_a.ov_usedw_max),      64'(vecs[i].umax));
            chk("vec_desc",   64'(bus_a.ov_descriptor),     64'(vecs[i].desc));
        end
        clr_a = 1'b0;

        // ---- round-robin: pointer left at 1, then both channels request continuously ----
        do_reset();
        ready_a = 1'b1;
        wr_a = 2'b01; new_desc(0);
        step();
        chk("rr_first", 64'(bus_a.ov_descriptor_ack), 64'(2'b01));
        wr_a = 2'b00;
        step(); step();
        wr_a = 2'b11; new_desc(0); new_desc(1);
        for (int i = 0; i < 12; i++) begin
            step();
            chk("rr_alternate", 64'(bus_a.ov_descriptor_ack), 64'((i % 2 == 0) ? 2'b10 : 2'b01));
            if (m_ack >= 0) new_desc(m_ack);
        end
        wr_a = '0;
        step(); step(); step();

        // ---- full: ready low, ch0 requests continuously ----
        do_reset();
        sent_q.delete();
        n_ack = 0; n_rx = 0;
        wr_a = 2'b01; new_desc(0);
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus_a.ov_descriptor_ack[0]) begin
                n_ack++;
                sent_q.push_back(cur_desc(0));
                new_desc(0);
            end
        end
        chk("full_ack_count", 64'(n_ack), 64'(16));
        chk("full_flag",      64'(bus_a.o_fifo_full), 64'(1));
        chk("full_usedw",     64'(bus_a.ov_fifo_usedw), 64'(16));
        ready_a = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus_a.o_descriptor_wr) begin
                n_rx++;
                if (sent_q.size() > 0) chk("fifo_order", 64'(bus_a.ov_descriptor), 64'(sent_q.pop_front()));
                else chk("extra_strobe", 64'(1), 64'(0));
            end
            if (bus_a.ov_descriptor_ack[0]) begin
                n_ack++;
                sent_q.push_back(cur_desc(0));
                wr_a[0] = 1'b0;
            end
        end
        chk("held_req_acked", 64'(n_ack), 64'(17));
        chk("drain_count",    64'(n_rx),  64'(17));

        // ---- simultaneous write and pop at usedw = 5 ----
        do_reset();
        wr_a = 2'b11; new_desc(0); new_desc(1);
        for (int i = 0; i < 20 && exp_q.size() < 5; i++) begin
            step();
            if (m_ack >= 0) new_desc(m_ack);
        end
        ready_a = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (m_ack >= 0) new_desc(m_ack);
            chk("simul_usedw", 64'(bus_a.ov_fifo_usedw), 64'(5));
        end
        chk("simul_peak", 64'(bus_a.ov_usedw_max), 64'(5));
        wr_a = '0;
        for (int i = 0; i < 10; i++) step();

        // ---- watermark: fill to 9, drain to 2, clear ----
        do_reset();
        n_ack = 0;
        wr_a = 2'b01; new_desc(0);
        for (int i = 0; i < 30 && n_ack < 9; i++) begin
            step();
            if (m_ack == 0) begin
                n_ack++;
                if (n_ack == 9) wr_a[0] = 1'b0;
                else new_desc(0);
            end
        end
        step(); step();
        chk("wm_fill", 64'(bus_a.ov_fifo_usedw), 64'(9));
        for (int i = 0; i < 20 && exp_q.size() > 2; i++) begin
            ready_a = 1'b1;
            step();
        end
        ready_a = 1'b0;
        step();
        chk("wm_drained", 64'(bus_a.ov_fifo_usedw), 64'(2));
        chk("wm_peak",    64'(bus_a.ov_usedw_max),  64'(9));
        clr_a = 1'b1;
        step();
        clr_a = 1'b0;
        chk("wm_clear",   64'(bus_a.ov_usedw_max),  64'(2));

        // ---- reset while a grant is in flight ----
        do_reset();
        wr_a = 2'b01; new_desc(0);
        step();
        wr_a = 2'b00;
        step(); step();
        chk("pre_rst_usedw", 64'(bus_a.ov_fifo_usedw), 64'(1));
        chk("pre_rst_ptr",   64'(bus_a.rr_ptr),        64'(1));
        wr_a = 2'b10; new_desc(1);
        #3 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_no_ack",   64'(bus_a.ov_descriptor_ack), 64'(0));
        chk("rst_no_write", 64'(bus_a.ov_fifo_usedw),     64'(0));
        wr_a = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_a();
        wr_a = 2'b10;
        step();
        chk("post_rst_ack", 64'(bus_a.ov_descriptor_ack), 64'(2'b10));
        wr_a = 2'b00;
        ready_a = 1'b1;
        step(); step(); step();

        // ---- fixed priority on the second instance ----
        do_reset();
        ready_b = 1'b1;
        wr_b = 2'b01; new_desc_b(0);
        step();
        chk("fp_solo", 64'(bus_b.ov_descriptor_ack), 64'(2'b01));
        wr_b = 2'b00;
        step(); step();
        wr_b = 2'b11; new_desc_b(0); new_desc_b(1);
        step();
        chk("fp_tie", 64'(bus_b.ov_descriptor_ack), 64'(2'b01));
        new_desc_b(0);
        step();
        chk("fp_masked", 64'(bus_b.ov_descriptor_ack), 64'(2'b10));
        new_desc_b(1);
        step();
        chk("fp_low_wins", 64'(bus_b.ov_descriptor_ack), 64'(2'b01));
        wr_b[0] = 1'b0;
        step();
        chk("fp_last", 64'(bus_b.ov_descriptor_ack), 64'(2'b10));
        wr_b = 2'b00;
        for (int i = 0; i < 5; i++) step();
        chk("fp_drain", 64'(bus_b.ov_fifo_usedw), 64'(0));

        // ---- randomized traffic against the model ----
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            bias = ((i / 250) % 2 == 0) ? 2 : 8;
            for (int c = 0; c < NUM_CH; c++) begin
                if (m_ack == c) begin
                    if ($urandom_range(0, 3) == 0) wr_a[c] = 1'b0;
                    else new_desc(c);
                end else if (!wr_a[c] && $urandom_range(0, 2) == 0) begin
                    wr_a[c] = 1'b1;
                    new_desc(c);
                end
            end
            ready_a = ($urandom_range(0, 9) < bias);
            clr_a   = ($urandom_range(0, 39) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
